// File: rtl/uart_rx_pkg.sv
// Shared definitions for the UART receiver datapath: sample-count encodings
// and the helpers that turn an encoding into a sample count.
package uart_rx_pkg;

    typedef enum logic [1:0] {
        SAMP_1 = 2'd0,
        SAMP_3 = 2'd1,
        SAMP_5 = 2'd2,
        SAMP_7 = 2'd3
    } samp_mode_e;

    localparam int MAX_K = 3;
    localparam int K_W   = $clog2(MAX_K + 1);

    // N = 2*mode + 1
    function automatic logic [3:0] mode_to_n(input logic [1:0] mode);
        return {1'b0, mode, 1'b1};
    endfunction

endpackage

// File: rtl/sample_window_calc.sv
// Combinational sample-window geometry from the latched configuration:
// first/last sample edge, decision edge, half-width K and a legality flag.
module sample_window_calc
    import uart_rx_pkg::*;
#(
    parameter int PRESCALE_W  = 6,
    parameter int MAX_SAMPLES = 7
) (
    input  logic [PRESCALE_W-1:0] cfg_presc,
    input  logic [1:0]            cfg_mode,
    output logic [PRESCALE_W:0]   first,
    output logic [PRESCALE_W:0]   last,
    output logic [PRESCALE_W:0]   dec,
    output logic [K_W-1:0]        k,
    output logic                  legal
);
    localparam int W = PRESCALE_W + 1;

    logic [3:0]   n;
    logic [W-1:0] n_ext;
    logic [W-1:0] mid;

    // One extra bit of width keeps underflow of mid/first visible.
    always_comb begin
        n     = mode_to_n(cfg_mode);
        n_ext = W'(n);
        k     = K_W'(cfg_mode);
        mid   = {2'b00, cfg_presc[PRESCALE_W-1:1]} - W'(1);
        first = mid - W'(k);
        last  = mid + W'(k);
        dec   = last + W'(1);
        legal = !cfg_presc[0]
             && ({1'b0, cfg_presc} >= (n_ext + W'(1)))
             && (n <= 4'(MAX_SAMPLES));
    end

endmodule

// File: rtl/uart_rx_multisampler.sv
// Oversampling bit sampler: collects 1/3/5/7 samples around the bit midpoint,
// majority-votes them and flags non-unanimous windows as noise.
module uart_rx_multisampler
    import uart_rx_pkg::*;
#(
    parameter int PRESCALE_W  = 6,
    parameter int MAX_SAMPLES = 7
) (
    input  logic                  CLK,
    input  logic                  RST,
    input  logic [PRESCALE_W-1:0] prescale,
    input  logic [1:0]            samp_mode,
    input  logic                  data_samp_en,
    input  logic                  RX_IN,
    input  logic [PRESCALE_W-1:0] edge_counter,
    output logic                  sampled_bit,
    output logic                  sample_valid,
    output logic                  noise_err,
    output logic                  cfg_err
);
    logic [PRESCALE_W-1:0] cfg_presc;
    samp_mode_e            cfg_mode;
    logic [PRESCALE_W:0]   first, last, dec;
    logic [K_W-1:0]        k;
    logic                  legal;
    logic [2:0]            ones;
    logic                  any0;
    logic                  win_act;
    logic [PRESCALE_W:0]   ec;
    logic                  samp_ok;

    sample_window_calc #(
        .PRESCALE_W (PRESCALE_W),
        .MAX_SAMPLES(MAX_SAMPLES)
    ) u_window (
        .cfg_presc(cfg_presc),
        .cfg_mode (cfg_mode),
        .first    (first),
        .last     (last),
        .dec      (dec),
        .k        (k),
        .legal    (legal)
    );

    assign ec      = {1'b0, edge_counter};
    assign samp_ok = data_samp_en && legal && !cfg_err;

    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            cfg_presc <= '0;
            cfg_mode  <= SAMP_1;
            cfg_err   <= 1'b0;
        end else begin
            if (!data_samp_en) begin
                cfg_presc <= prescale;
                cfg_mode  <= samp_mode_e'(samp_mode);
            end
            cfg_err <= !legal;
        end
    end

    // win_act marks a window that was loaded at `first`; a skipped or
    // reset-interrupted window never reaches a decision.
    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            ones    <= '0;
            any0    <= 1'b0;
            win_act <= 1'b0;
        end else if (!data_samp_en) begin
            ones    <= '0;
            any0    <= 1'b0;
            win_act <= 1'b0;
        end else if (samp_ok) begin
            if (ec == first) begin
                ones    <= {2'b00, RX_IN};
                any0    <= ~RX_IN;
                win_act <= 1'b1;
            end else if (win_act && ec > first && ec <= last) begin
                ones <= ones + {2'b00, RX_IN};
                any0 <= any0 | ~RX_IN;
            end else if (ec == dec) begin
                win_act <= 1'b0;
            end
        end
    end

    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            sampled_bit  <= 1'b0;
            sample_valid <= 1'b0;
            noise_err    <= 1'b0;
        end else begin
            sample_valid <= 1'b0;
            if (samp_ok && win_act && ec == dec) begin
                sample_valid <= 1'b1;
                sampled_bit  <= (ones > {1'b0, k});
                noise_err    <= (ones != 3'd0) && any0;
            end
        end
    end

endmodule

// File: tb/tb_uart_rx_multisampler.sv
// Directed bench for uart_rx_multisampler: window placement, voting, noise,
// config latching, cfg_err, abort, skipped window and async reset.
module tb_uart_rx_multisampler;
    logic       CLK = 1'b0;
    logic       RST;
    logic [5:0] prescale;
    logic [1:0] samp_mode;
    logic       data_samp_en;
    logic       RX_IN;
    logic [5:0] edge_counter;
    logic       sampled_bit;
    logic       sample_valid;
    logic       noise_err;
    logic       cfg_err;

    int checks   = 0;
    int failures = 0;

    uart_rx_multisampler #(.PRESCALE_W(6), .MAX_SAMPLES(7)) dut (
        .CLK         (CLK),
        .RST         (RST),
        .prescale    (prescale),
        .samp_mode   (samp_mode),
        .data_samp_en(data_samp_en),
        .RX_IN       (RX_IN),
        .edge_counter(edge_counter),
        .sampled_bit (sampled_bit),
        .sample_valid(sample_valid),
        .noise_err   (noise_err),
        .cfg_err     (cfg_err)
    );

    always #5 CLK = ~CLK;

    initial begin
        #200000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog expired");
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic idle(input int n);
        repeat (n) begin
            @(posedge CLK);
            #1;
        end
    endtask

    // Drives edges from..to with RX_IN = pat[edge]; counts valid pulses and
    // records the edge whose clock registered the last pulse.
    task automatic drive(input int from, input int to, input logic [63:0] pat,
                         output int nv, output int ve);
        nv = 0;
        ve = -1;
        for (int e = from; e <= to; e++) begin
            edge_counter = e[5:0];
            RX_IN        = pat[e];
            @(posedge CLK);
            #1;
            if (sample_valid) begin
                nv++;
                ve = e;
            end
        end
    endtask

    task automatic set_cfg(input int p, input int m);
        data_samp_en = 1'b0;
        prescale     = p[5:0];
        samp_mode    = m[1:0];
        idle(3);
    endtask

    initial begin
        int nv, ve, total;
        RST          = 1'b0;
        prescale     = 6'd8;
        samp_mode    = 2'd1;
        data_samp_en = 1'b0;
        RX_IN        = 1'b1;
        edge_counter = '0;
        #2;
        check("rst_bit", 32'(sampled_bit), 32'd0);
        check("rst_valid", 32'(sample_valid), 32'd0);
        check("rst_noise", 32'(noise_err), 32'd0);
        check("rst_cfg_err", 32'(cfg_err), 32'd0);
        idle(2);
        RST = 1'b1;
        idle(3);
        check("cfg8_legal", 32'(cfg_err), 32'd0);

        // prescale 8, N=3: samples at 2,3,4, decision at 5
        data_samp_en = 1'b1;
        drive(0, 7, 64'h14, nv, ve);
        check("n3_pulses", 32'(nv), 32'd1);
        check("n3_edge", 32'(ve), 32'd5);
        check("n3_bit", 32'(sampled_bit), 32'd1);
        check("n3_noise", 32'(noise_err), 32'd1);
        drive(0, 7, 64'hFF, nv, ve);
        check("n3b_pulses", 32'(nv), 32'd1);
        check("n3b_bit", 32'(sampled_bit), 32'd1);
        check("n3b_noise", 32'(noise_err), 32'd0);

        // prescale 16, N=5: samples 5..9, decision at 10, ten bits
        set_cfg(16, 2);
        data_samp_en = 1'b1;
        total = 0;
        for (int b = 0; b < 10; b++) begin
            drive(0, 15, 64'h0, nv, ve);
            total += nv;
        end
        check("n5_total", 32'(total), 32'd10);
        check("n5_edge", 32'(ve), 32'd10);
        check("n5_bit", 32'(sampled_bit), 32'd0);
        check("n5_noise", 32'(noise_err), 32'd0);

        // prescale 8, N=7: samples 0..6 with four ones, decision at 7
        set_cfg(8, 3);
        data_samp_en = 1'b1;
        drive(0, 7, 64'h55, nv, ve);
        check("n7_pulses", 32'(nv), 32'd1);
        check("n7_edge", 32'(ve), 32'd7);
        check("n7_bit", 32'(sampled_bit), 32'd1);
        check("n7_noise", 32'(noise_err), 32'd1);

        // prescale 6 cannot hold 7 samples
        set_cfg(6, 3);
        check("p6_cfg_err", 32'(cfg_err), 32'd1);
        data_samp_en = 1'b1;
        drive(0, 5, 64'h3F, nv, ve);
        check("p6_pulses", 32'(nv), 32'd0);

        // prescale 2, N=1: single sample at edge 0, decision at 1
        set_cfg(2, 0);
        check("p2_cfg_err", 32'(cfg_err), 32'd0);
        data_samp_en = 1'b1;
        drive(0, 1, 64'h2, nv, ve);
        check("n1a_edge", 32'(ve), 32'd1);
        check("n1a_bit", 32'(sampled_bit), 32'd0);
        drive(0, 1, 64'h1, nv, ve);
        check("n1b_pulses", 32'(nv), 32'd1);
        check("n1b_bit", 32'(sampled_bit), 32'd1);

        // abort at edge 4: no pulse, sampled_bit keeps 1
        set_cfg(16, 2);
        data_samp_en = 1'b1;
        drive(0, 3, 64'h0, nv, ve);
        total = nv;
        data_samp_en = 1'b0;
        drive(4, 15, 64'h0, nv, ve);
        total += nv;
        check("abort_pulses", 32'(total), 32'd0);
        check("abort_hold", 32'(sampled_bit), 32'd1);

        // config changes while enabled are ignored until the enable drops
        data_samp_en = 1'b1;
        prescale     = 6'd8;
        samp_mode    = 2'd1;
        drive(0, 15, 64'h0, nv, ve);
        check("frozen_pulses", 32'(nv), 32'd1);
        check("frozen_edge", 32'(ve), 32'd10);
        check("frozen_bit", 32'(sampled_bit), 32'd0);
        data_samp_en = 1'b0;
        idle(3);
        data_samp_en = 1'b1;
        drive(0, 7, 64'hFF, nv, ve);
        check("relatch_edge", 32'(ve), 32'd5);
        check("relatch_bit", 32'(sampled_bit), 32'd1);

        // async reset mid-window, then a partial window must not decide
        drive(0, 3, 64'hFF, nv, ve);
        RST = 1'b0;
        #1;
        check("arst_bit", 32'(sampled_bit), 32'd0);
        check("arst_valid", 32'(sample_valid), 32'd0);
        check("arst_noise", 32'(noise_err), 32'd0);
        check("arst_cfg_err", 32'(cfg_err), 32'd0);
        idle(2);
        data_samp_en = 1'b0;
        RST = 1'b1;
        idle(3);
        data_samp_en = 1'b1;
        drive(4, 7, 64'hFF, nv, ve);
        check("partial_pulses", 32'(nv), 32'd0);
        drive(0, 7, 64'hFF, nv, ve);
        check("post_rst_pulses", 32'(nv), 32'd1);
        check("post_rst_edge", 32'(ve), 32'd5);
        check("post_rst_bit", 32'(sampled_bit), 32'd1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
